// File: rtl/mem_arbiter.sv
// Two-port (CPU/accelerator) arbiter onto one shared word memory.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin ties; default is CPU priority.
module mem_arbiter #(
  parameter int AW    = 3,
  parameter int DW    = 16,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          c_req,
  input  logic          c_wr,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rdata,
  input  logic          a_req,
  input  logic          a_wr,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_idata,
  output logic          m_wr,
  input  logic [DW-1:0] m_odata,
  output logic          busy
);

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  state_t state_q, state_d;

  logic          cmd_wr_q;
  logic [AW-1:0] cmd_addr_q;
  logic [DW-1:0] cmd_wdata_q;
  logic          cmd_acc_q;

  logic          latch;
  logic          access;
  logic          live;
  logic          in_range;
  logic          win_acc;
  logic          win_wr;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_wdata;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_acc_q;

  // On a tie the port not served last wins.
  always_comb begin
    win_acc = a_req && (!c_req || !last_acc_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_acc_q <= 1'b1;
    end else if (live) begin
      last_acc_q <= cmd_acc_q;
    end
  end
`else
  always_comb begin
    win_acc = a_req && !c_req;
  end
`endif

  always_comb begin
    win_wr    = c_wr;
    win_addr  = c_addr;
    win_wdata = c_wdata;
    if (win_acc) begin
      win_wr    = a_wr;
      win_addr  = a_addr;
      win_wdata = a_wdata;
    end
  end

  always_comb begin
    state_d = state_q;
    latch   = 1'b0;
    access  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (c_req || a_req) begin
          latch   = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        access  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset landing on the access cycle cancels the write and the grant.
  always_comb begin
    live     = access && !rst;
    in_range = {1'b0, cmd_addr_q} < DEPTH_W;
    busy     = live;
    c_gnt    = live && !cmd_acc_q;
    a_gnt    = live && cmd_acc_q;
    m_wr     = live && cmd_wr_q && in_range;
    m_addr   = cmd_addr_q;
    m_idata  = cmd_wdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cmd_wr_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      cmd_acc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (latch) begin
        cmd_wr_q    <= win_wr;
        cmd_addr_q  <= win_addr;
        cmd_wdata_q <= win_wdata;
        cmd_acc_q   <= win_acc;
      end
    end
  end

  // Out-of-range reads complete normally but return zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      c_rvalid <= 1'b0;
      a_rvalid <= 1'b0;
      c_rdata  <= '0;
      a_rdata  <= '0;
    end else begin
      c_rvalid <= access && !cmd_wr_q && !cmd_acc_q;
      a_rvalid <= access && !cmd_wr_q && cmd_acc_q;
      if (access && !cmd_wr_q && !cmd_acc_q) begin
        c_rdata <= in_range ? m_odata : '0;
      end
      if (access && !cmd_wr_q && cmd_acc_q) begin
        a_rdata <= in_range ? m_odata : '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 4-word memory.
// Inputs change and outputs are checked on the falling clock edge.
module tb_mem_arbiter;

  localparam int AW = 3;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          c_req, c_wr, a_req, a_wr;
  logic [AW-1:0] c_addr, a_addr;
  logic [DW-1:0] c_wdata, a_wdata;
  logic          c_gnt, c_rvalid, a_gnt, a_rvalid;
  logic [DW-1:0] c_rdata, a_rdata;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_idata, m_odata;
  logic          m_wr, busy;

  logic [DW-1:0] mem [0:3];
  logic [DW-1:0] prev1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .DW(DW), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_wr(c_wr), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .a_req(a_req), .a_wr(a_wr), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .m_addr(m_addr), .m_idata(m_idata), .m_wr(m_wr),
    .m_odata(m_odata), .busy(busy)
  );

  // Out-of-range words read as a non-zero pattern so zeroing is visible.
  assign m_odata = (m_addr < 3'd4) ? mem[m_addr[1:0]] : 16'hDEAD;

  always @(posedge clk) begin
    if (m_wr && m_addr < 3'd4) mem[m_addr[1:0]] <= m_idata;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_ports();
    c_req = 0; c_wr = 0; c_addr = '0; c_wdata = '0;
    a_req = 0; a_wr = 0; a_addr = '0; a_wdata = '0;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) mem[i] = '0;
    rst = 1;
    idle_ports();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_c_gnt", c_gnt, 0);
    chk("rst_a_gnt", a_gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_m_wr", m_wr, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_c_rvalid", c_rvalid, 0);
    chk("rst_a_rdata", a_rdata, 0);

    // CPU write addr 2
    rst = 0;
    c_req = 1; c_wr = 1; c_addr = 3'd2; c_wdata = 16'hBEEF;
    @(negedge clk); #1;
    chk("w_c_gnt", c_gnt, 1);
    chk("w_a_gnt", a_gnt, 0);
    chk("w_busy", busy, 1);
    chk("w_m_wr", m_wr, 1);
    chk("w_m_addr", m_addr, 2);
    chk("w_m_idata", m_idata, 16'hBEEF);
    idle_ports();
    @(negedge clk); #1;
    chk("w_c_rvalid", c_rvalid, 0);
    chk("w_idle_gnt", c_gnt, 0);
    chk("w_idle_busy", busy, 0);
    chk("w_idle_m_wr", m_wr, 0);
    chk("w_hold_addr", m_addr, 2);
    chk("w_mem2", mem[2], 16'hBEEF);

    // Accelerator read addr 2
    a_req = 1; a_wr = 0; a_addr = 3'd2;
    @(negedge clk); #1;
    chk("r_a_gnt", a_gnt, 1);
    chk("r_c_gnt", c_gnt, 0);
    chk("r_m_wr", m_wr, 0);
    idle_ports();
    @(negedge clk); #1;
    chk("r_a_rvalid", a_rvalid, 1);
    chk("r_a_rdata", a_rdata, 16'hBEEF);
    chk("r_c_rvalid", c_rvalid, 0);
    @(negedge clk); #1;
    chk("r_a_rvalid_end", a_rvalid, 0);
    chk("r_a_rdata_hold", a_rdata, 16'hBEEF);

    // Both ports request continuously
    c_req = 1; c_wr = 1; c_addr = 3'd0; c_wdata = 16'h1111;
    a_req = 1; a_wr = 1; a_addr = 3'd1; a_wdata = 16'h2222;
    for (int g = 0; g < 4; g++) begin
      @(negedge clk); #1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      chk($sformatf("tie_c_gnt%0d", g), c_gnt, (g % 2 == 0));
      chk($sformatf("tie_a_gnt%0d", g), a_gnt, (g % 2 == 1));
`else
      chk($sformatf("tie_c_gnt%0d", g), c_gnt, 1);
      chk($sformatf("tie_a_gnt%0d", g), a_gnt, 0);
`endif
      if (g == 3) idle_ports();
      @(negedge clk); #1;
      chk($sformatf("tie_gap%0d", g), c_gnt | a_gnt, 0);
    end

    // Out-of-range write then read at addr 5
    c_req = 1; c_wr = 1; c_addr = 3'd5; c_wdata = 16'h1234;
    @(negedge clk); #1;
    chk("oor_w_gnt", c_gnt, 1);
    chk("oor_w_m_wr", m_wr, 0);
    chk("oor_w_m_addr", m_addr, 5);
    idle_ports();
    @(negedge clk); #1;
    chk("oor_w_rvalid", c_rvalid, 0);
    c_req = 1; c_wr = 0; c_addr = 3'd5;
    @(negedge clk); #1;
    chk("oor_r_gnt", c_gnt, 1);
    idle_ports();
    @(negedge clk); #1;
    chk("oor_r_rvalid", c_rvalid, 1);
    chk("oor_r_rdata", c_rdata, 0);

    // Reset during the access of a write to addr 1
    prev1 = mem[1];
    c_req = 1; c_wr = 1; c_addr = 3'd1; c_wdata = 16'h5A5A;
    @(negedge clk);
    rst = 1;
    idle_ports();
    #1;
    chk("ra_m_wr", m_wr, 0);
    chk("ra_c_gnt", c_gnt, 0);
    chk("ra_busy", busy, 0);
    @(negedge clk); #1;
    chk("ra_mem1", mem[1], prev1);
    chk("ra_c_rvalid", c_rvalid, 0);
    chk("ra_m_addr", m_addr, 0);
    chk("ra_m_idata", m_idata, 0);
    chk("ra_a_rdata", a_rdata, 0);
    chk("ra_c_rdata", c_rdata, 0);

    // After reset the CPU wins a tie in either build
    rst = 0;
    c_req = 1; c_wr = 0; c_addr = 3'd2;
    a_req = 1; a_wr = 0; a_addr = 3'd0;
    @(negedge clk); #1;
    chk("pr_c_gnt", c_gnt, 1);
    chk("pr_a_gnt", a_gnt, 0);
    c_req = 0;
    @(negedge clk); #1;
    chk("pr_c_rvalid", c_rvalid, 1);
    chk("pr_c_rdata", c_rdata, 16'hBEEF);
    chk("pr_a_rvalid", a_rvalid, 0);
    @(negedge clk); #1;
    chk("pr_a_gnt2", a_gnt, 1);
    idle_ports();
    @(negedge clk); #1;
    chk("pr_a_rvalid2", a_rvalid, 1);
    chk("pr_a_rdata", a_rdata, 16'h1111);
    chk("pr_c_rdata_hold", c_rdata, 16'hBEEF);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
